cordic_amplitude_angle: RTL and testbench



---
 rtl/cordic_amplitude_angle.sv | 194 +++++++++++++++++++
 tb/tb_cordic_amplitude_angle.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cordic_amplitude_angle.sv
// Pipelined vectoring-mode CORDIC: Q16.16 (x, y) -> Q16.16 amplitude and angle, latency PIPELINE+3.
// Define ANGLE_RADIAN_EN to produce the angle in radians instead of degrees.
module cordic_amplitude_angle #(
    parameter int unsigned PIPELINE = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [31:0] x,
    input  logic signed [31:0] y,
    input  logic               pre_vaild,
    output logic signed [31:0] amplitude,
    output logic signed [31:0] angle,
    output logic               post_vaild
);

    localparam int unsigned Lat = PIPELINE + 3;

`ifdef ANGLE_RADIAN_EN
    localparam logic signed [33:0] HalfTurn = 34'sd205887;
`else
    localparam logic signed [33:0] HalfTurn = 34'sd11796480;
`endif
    localparam logic signed [33:0] FullTurn = HalfTurn + HalfTurn;
    localparam logic signed [63:0] GainComp = 64'sd39797;
    localparam logic signed [33:0] SatMax   = 34'sd2147483647;
    localparam logic signed [33:0] SatMin   = -34'sd2147483648;

    function automatic logic signed [33:0] atan_lut(input int unsigned i);
        logic signed [33:0] v;
        case (i)
`ifdef ANGLE_RADIAN_EN
            0:       v = 34'sd51472;
            1:       v = 34'sd30386;
            2:       v = 34'sd16055;
            3:       v = 34'sd8150;
            4:       v = 34'sd4091;
            5:       v = 34'sd2047;
            6:       v = 34'sd1024;
            7:       v = 34'sd512;
            8:       v = 34'sd256;
            9:       v = 34'sd128;
            10:      v = 34'sd64;
            11:      v = 34'sd32;
            12:      v = 34'sd16;
            13:      v = 34'sd8;
            14:      v = 34'sd4;
            15:      v = 34'sd2;
`else
            0:       v = 34'sd2949120;
            1:       v = 34'sd1740967;
            2:       v = 34'sd919879;
            3:       v = 34'sd466945;
            4:       v = 34'sd234378;
            5:       v = 34'sd117303;
            6:       v = 34'sd58666;
            7:       v = 34'sd29334;
            8:       v = 34'sd14667;
            9:       v = 34'sd7333;
            10:      v = 34'sd3666;
            11:      v = 34'sd1833;
            12:      v = 34'sd916;
            13:      v = 34'sd458;
            14:      v = 34'sd229;
            15:      v = 34'sd115;
`endif
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic signed [31:0] sat32(input logic signed [33:0] v);
        logic signed [31:0] r;
        if (v > SatMax) begin
            r = SatMax[31:0];
        end else if (v < SatMin) begin
            r = SatMin[31:0];
        end else begin
            r = v[31:0];
        end
        return r;
    endfunction

    // Index 0 is the pre-rotation register, index i+1 the result of micro-rotation i.
    logic signed [33:0] x_q     [PIPELINE+1];
    logic signed [33:0] y_q     [PIPELINE+1];
    logic signed [33:0] z_q     [PIPELINE+1];
    logic        [1:0]  off_q   [PIPELINE+1];
    logic               use_z_q [PIPELINE+1];
    logic signed [33:0] x_d     [PIPELINE+1];
    logic signed [33:0] y_d     [PIPELINE+1];
    logic signed [33:0] z_d     [PIPELINE+1];
    logic        [1:0]  off_d   [PIPELINE+1];
    logic               use_z_d [PIPELINE+1];

    logic signed [33:0] x_ext;
    logic signed [33:0] y_ext;
    logic signed [63:0] prod;
    logic signed [33:0] off_val;
    logic signed [33:0] ang_sum;
    logic signed [33:0] amp_d;
    logic signed [33:0] ang_d;
    logic signed [33:0] amp_q;
    logic signed [33:0] ang_q;
    logic signed [31:0] amp_out_q;
    logic signed [31:0] ang_out_q;
    logic [Lat-1:0]     vld_q;

    assign x_ext = 34'(x);
    assign y_ext = 34'(y);

    // off code: 2'b01 adds +half turn, 2'b10 adds -half turn.
    // use_z is cleared when y is exactly zero so the on-axis angle comes out exact
    // and the reset state of the pipeline drains as amplitude 0, angle 0.
    always_comb begin
        x_d[0]     = x_ext;
        y_d[0]     = y_ext;
        z_d[0]     = '0;
        off_d[0]   = 2'b00;
        use_z_d[0] = (y != 32'sd0);
        if (x[31]) begin
            x_d[0]   = -x_ext;
            y_d[0]   = -y_ext;
            off_d[0] = y[31] ? 2'b10 : 2'b01;
        end
        for (int unsigned i = 0; i < PIPELINE; i++) begin
            off_d[i+1]   = off_q[i];
            use_z_d[i+1] = use_z_q[i];
            if (!y_q[i][33]) begin
                x_d[i+1] = x_q[i] + (y_q[i] >>> i);
                y_d[i+1] = y_q[i] - (x_q[i] >>> i);
                z_d[i+1] = z_q[i] + atan_lut(i);
            end else begin
                x_d[i+1] = x_q[i] - (y_q[i] >>> i);
                y_d[i+1] = y_q[i] + (x_q[i] >>> i);
                z_d[i+1] = z_q[i] - atan_lut(i);
            end
        end
    end

    assign prod  = 64'(x_q[PIPELINE]) * GainComp;
    assign amp_d = 34'(prod >>> 16);

    always_comb begin
        case (off_q[PIPELINE])
            2'b01:   off_val = HalfTurn;
            2'b10:   off_val = -HalfTurn;
            default: off_val = '0;
        endcase
        ang_sum = use_z_q[PIPELINE] ? z_q[PIPELINE] + off_val : off_val;
        // Keep the CORDIC residue from pushing the result outside (-half, +half].
        if (ang_sum > HalfTurn) begin
            ang_d = ang_sum - FullTurn;
        end else if (ang_sum <= -HalfTurn) begin
            ang_d = ang_sum + FullTurn;
        end else begin
            ang_d = ang_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i <= PIPELINE; i++) begin
                x_q[i]     <= '0;
                y_q[i]     <= '0;
                z_q[i]     <= '0;
                off_q[i]   <= '0;
                use_z_q[i] <= 1'b0;
            end
            amp_q     <= '0;
            ang_q     <= '0;
            amp_out_q <= '0;
            ang_out_q <= '0;
            vld_q     <= '0;
        end else begin
            for (int unsigned i = 0; i <= PIPELINE; i++) begin
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
                z_q[i]     <= z_d[i];
                off_q[i]   <= off_d[i];
                use_z_q[i] <= use_z_d[i];
            end
            amp_q     <= amp_d;
            ang_q     <= ang_d;
            amp_out_q <= sat32(amp_q);
            ang_out_q <= sat32(ang_q);
            vld_q     <= {vld_q[Lat-2:0], pre_vaild};
        end
    end

    assign amplitude  = amp_out_q;
    assign angle      = ang_out_q;
    assign post_vaild = vld_q[Lat-1];

endmodule

// File: tb/tb_cordic_amplitude_angle.sv
// Self-checking bench for cordic_amplitude_angle: directed and random samples against a
// real-arithmetic sqrt/atan2 model, plus valid-latency, reset and fill checks.
module tb_cordic_amplitude_angle;

    localparam int unsigned PIPELINE = 16;
    localparam int unsigned Lat      = PIPELINE + 3;
    localparam int          S        = 65536;
    localparam real         Pi       = 3.14159265358979323846;
`ifdef ANGLE_RADIAN_EN
    localparam real    AngScale = 65536.0;
    localparam longint AngTol   = 16;
`else
    localparam real    AngScale = 65536.0 * 180.0 / Pi;
    localparam longint AngTol   = 656;
`endif
    localparam longint AngTurn = longint'(2.0 * Pi * AngScale);

    logic               clk;
    logic               rst_n;
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic               pre_vaild;
    logic signed [31:0] amplitude;
    logic signed [31:0] angle;
    logic               post_vaild;

    cordic_amplitude_angle #(
        .PIPELINE(PIPELINE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x         (x),
        .y         (y),
        .pre_vaild (pre_vaild),
        .amplitude (amplitude),
        .angle     (angle),
        .post_vaild(post_vaild)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int xv;
        int yv;
    } sample_t;

    sample_t     hist[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input longint got, input longint exp,
                         input longint tol, input longint turn);
        longint diff;
        n_checks++;
        diff = got - exp;
        if (turn != 0) begin
            diff = diff % turn;
            if (diff > turn / 2) diff -= turn;
            else if (diff < -(turn / 2)) diff += turn;
        end
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", tag, got, exp, tol, $time);
        end
    endtask

    function automatic longint ref_amp(input int xv, input int yv);
        real    r;
        longint a;
        r = $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv));
        a = longint'(r);
        if (a > 64'sd2147483647) a = 64'sd2147483647;
        return a;
    endfunction

    function automatic longint ref_ang(input int xv, input int yv);
        return longint'($atan2(real'(yv), real'(xv)) * AngScale);
    endfunction

    function automatic longint amp_tol(input longint a);
        longint t;
        t = longint'(real'(a) * 0.0002);
        return (t < 4) ? 64'sd4 : t;
    endfunction

    function automatic longint abs_l(input int v);
        return (v < 0) ? -longint'(v) : longint'(v);
    endfunction

    always @(posedge clk) begin
        if (rst_n) hist.push_back('{v: pre_vaild, xv: x, yv: y});
    end

    always @(negedge clk) begin
        sample_t s;
        longint  ea;
        if (rst_n) begin
            if (hist.size() >= Lat) begin
                s = hist.pop_front();
                check("post_vaild", post_vaild, s.v, 0, 0);
                if (s.v || (s.xv == 0 && s.yv == 0)) begin
                    ea = ref_amp(s.xv, s.yv);
                    check("amplitude", amplitude, ea, amp_tol(ea), 0);
                    check("angle", angle, ref_ang(s.xv, s.yv), (s.yv == 0) ? 0 : AngTol, AngTurn);
                end
            end else begin
                check("fill_vaild", post_vaild, 0, 0, 0);
                check("fill_amp", amplitude, 0, 0, 0);
                check("fill_ang", angle, 0, 0, 0);
            end
        end
    end

    task automatic drive(input bit v, input int xv, input int yv);
        pre_vaild = v;
        x         = xv;
        y         = yv;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_xy(output int xv, output int yv);
        do begin
            xv = int'($urandom) >>> $urandom_range(0, 10);
            yv = int'($urandom) >>> $urandom_range(0, 10);
        end while (abs_l(xv) < 64'sd1048576 && abs_l(yv) < 64'sd1048576);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_amp"}, amplitude, 0, 0, 0);
        check({tag, "_ang"}, angle, 0, 0, 0);
        check({tag, "_vld"}, post_vaild, 0, 0, 0);
    endtask

    initial begin
        int xv;
        int yv;
        rst_n     = 1'b0;
        pre_vaild = 1'b0;
        x         = '0;
        y         = '0;
        #100;
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) drive(0, 0, 0);

        // first-quadrant burst
        drive(1, 1 * S, 1 * S);
        drive(1, 2 * S, 4 * S);
        drive(1, 10 * S, 15 * S);
        repeat (3) drive(0, 0, 0);

        // left half-plane
        drive(1, -10 * S, -15 * S);
        drive(1, -10 * S, 15 * S);
        drive(1, -2 * S, -2 * S);
        drive(0, 0, 0);

        // axes, large values and full-scale extremes
        drive(1, 10 * S, 0);
        drive(1, 0, 10 * S);
        drive(1, 100 * S, 100 * S);
        drive(1, 2 * S, -4 * S);
        drive(1, 0, -7 * S);
        drive(1, 32'h7fffffff, 32'h7fffffff);
        drive(1, 32'h80000000, 32'h80000000);
        drive(1, 32'h80000000, 0);
        drive(1, 32'h7fffffff, 32'h80000000);

        // 20-cycle gap with junk on the data inputs, then edge cases
        repeat (20) drive(0, int'($urandom), int'($urandom));
        drive(1, 0, 0);
        drive(1, -5 * S, 0);
        drive(1, 3 * S, 0);

        repeat (300) begin
            rand_xy(xv, yv);
            drive($urandom_range(0, 3) != 0, xv, yv);
        end

        // reset in the middle of a burst
        repeat (6) begin
            rand_xy(xv, yv);
            drive(1, xv, yv);
        end
        #2;
        rst_n = 1'b0;
        hist.delete();
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) begin
            rand_xy(xv, yv);
            drive(1, xv, yv);
        end
        repeat (Lat + 4) drive(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
